otter_alu_mc: RTL
=================

// Module: otter_alu_mc
// PURPOSE
//  Parametrised multi-cycle execute unit for the OTTER pipeline: base RV32I ALU ops plus optional RV32M.
//  Registered result; valid/ready on both sides, so the EX stage can stall on long ops.
//  Sits in EX between the operand-forwarding muxes and the EX/MEM register.
// PARAMETERS
//  XLEN   32  operand/result width; power of 2, >= 8
//  SHW    $clog2(XLEN)  shift-amount width (localparam, derived)
// PORTS
//  CLK        in   1     clock, rising edge
//  RST_N      in   1     asynchronous active-low reset
//  FLUSH      in   1     synchronous abort of in-flight op (pipeline flush)
//  IN_VALID   in   1     operands/op valid
//  IN_READY   out  1     unit can accept this cycle
//  ALU_FUN    in   5     [4]=M-ext select; [3:0] base code (ADD 0000, SUB 1000, OR 0110, AND 0111, XOR 0100, SRL 0101,
//                        SLL 0001, SRA 1101, SLT 0010, SLTU 0011, LUI 1001); when [4]=1, [2:0]=RV32M funct3
//  A, B       in   XLEN  operands
//  OUT_VALID  out  1     ALU_OUT valid
//  OUT_READY  in   1     consumer takes result
//  ALU_OUT    out  XLEN  result
//  ILLEGAL    out  1     qualifies ALU_OUT: op undefined/unsupported
// BEHAVIOUR
//  - Reset: state IDLE, OUT_VALID=0, ALU_OUT=0, ILLEGAL=0, IN_READY=1. Reset mid-op discards the op.
//  - FSM IDLE -> (accept base op) DONE; IDLE -> (accept M op) BUSY; BUSY -> (count==XLEN) DONE;
//    DONE -> (OUT_READY & !IN_VALID) IDLE; DONE -> (OUT_READY & IN_VALID) DONE or BUSY (back-to-back accept).
//  - IN_READY = (state==IDLE) | (state==DONE & OUT_READY). Accept = IN_VALID & IN_READY.
//  - Base ops: latency 1 (OUT_VALID high the cycle after accept). Shifts use B[SHW-1:0]; SLT/SLTU give 0/1
//    zero-extended; LUI passes A; undefined base code -> ALU_OUT=0, ILLEGAL=1.
//  - M ops: radix-2 iterative, exactly XLEN BUSY cycles, OUT_VALID at accept+XLEN+1. Signed ops on magnitudes,
//    sign fixed at end. MUL low half; MULH/MULHSU/MULHU high half of 2*XLEN product.
//  - DIV/DIVU by 0: quotient all ones; REM/REMU by 0: A. DIV of -2^(XLEN-1) by -1: quotient -2^(XLEN-1), REM 0.
//  - ALU_OUT/ILLEGAL held stable while OUT_VALID & !OUT_READY. A, B, ALU_FUN captured at accept; later input changes ignored.
//  - FLUSH: next state IDLE, OUT_VALID=0, IN_READY=1 the following cycle; FLUSH beats an accept in the same cycle.
// CONFIGURATION
//  OTTER_ALU_MULDIV_EN defined: M ops implemented as above.
//  Undefined: no multiply/divide datapath; any ALU_FUN[4]=1 completes in 1 cycle with ALU_OUT=0, ILLEGAL=1; BUSY unreachable.
// STRUCTURE
//  otter_alu_pkg: alu_op_t enum (base codes), md_op_t enum (funct3), alu_state_t (IDLE/BUSY/DONE).
//  Sub-module otter_muldiv_iter (start, op, A, B -> done, result; XLEN-parametrised counter + shift registers),
//  instantiated only under OTTER_ALU_MULDIV_EN.
// TESTING
//  1. ADD A=0x7FFFFFFF B=1, OUT_READY=1 -> next cycle OUT_VALID=1, ALU_OUT=0x80000000, ILLEGAL=0.
//  2. SRA A=0x80000000 B=0x00000024 -> 0xF8000000 (shamt 4); SLTU A=1 B=0xFFFFFFFF -> 1.
//  3. MULDIV_EN: DIV A=0x80000000 B=0xFFFFFFFF -> 0x80000000 after 33 cycles; DIVU A=5 B=0 -> 0xFFFFFFFF; REM A=5 B=0 -> 5.
//  4. Backpressure: ADD 3+4 with OUT_READY=0 for 5 cycles -> ALU_OUT=7 stable, IN_READY=0; new op accepted in release cycle.
//  5. FLUSH on 10th BUSY cycle of MULHU -> OUT_VALID never rises; next ADD 1+1 returns 2 with latency 1.
//  6. MULDIV_EN undefined: ALU_FUN=5'b10000 -> 1 cycle, ALU_OUT=0, ILLEGAL=1; RST_N low mid-op -> all outputs at reset values immediately.

Source files
------------

// File: rtl/otter_alu_pkg.sv
// otter_alu_pkg: opcode, M-extension funct3 and FSM state encodings shared by the OTTER execute unit.
package otter_alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_op_t;
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } alu_state_t;
endpackage

// File: rtl/otter_muldiv_iter.sv
// otter_muldiv_iter: radix-2 shift-add multiplier / restoring divider, XLEN iterations on operand magnitudes.
// done_o is high during the last iteration; result_o is the sign-corrected value that iteration produces.
module otter_muldiv_iter
    import otter_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int SHW = $clog2(XLEN);
    md_op_t          op_q;
    logic            busy_q, div_q, neg_q, negr_q, zero_q;
    logic [SHW-1:0]  cnt_q;
    logic [XLEN-1:0] hi_q, lo_q, m_q;
    md_op_t          op;
    logic            sa, sb, na, nb, ge;
    logic [XLEN-1:0] ma, mb, hi_d, lo_d, quo, rem;
    logic [XLEN:0]   sum, sh, diff;
    logic [2*XLEN-1:0] prod;
    assign op = md_op_t'(op_i);
    assign sa = op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    assign sb = op inside {MD_MULH, MD_DIV, MD_REM};
    assign na = sa & a_i[XLEN-1];
    assign nb = sb & b_i[XLEN-1];
    assign ma = na ? -a_i : a_i;
    assign mb = nb ? -b_i : b_i;
    // hi holds the partial product / running remainder, lo the multiplier / quotient being shifted
    assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign sh   = {hi_q, lo_q[XLEN-1]};
    assign diff = sh - {1'b0, m_q};
    assign ge   = ~diff[XLEN];
    assign hi_d = div_q ? (ge ? diff[XLEN-1:0] : sh[XLEN-1:0]) : sum[XLEN:1];
    assign lo_d = div_q ? {lo_q[XLEN-2:0], ge} : {sum[0], lo_q[XLEN-1:1]};
    assign prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    assign quo  = zero_q ? '1 : (neg_q ? -lo_d : lo_d);
    assign rem  = negr_q ? -hi_d : hi_d;
    assign done_o   = busy_q & (cnt_q == SHW'(XLEN - 1));
    assign result_o = div_q ? ((op_q inside {MD_REM, MD_REMU}) ? rem : quo)
                            : ((op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q   <= MD_MUL;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
        end else if (start_i) begin
            op_q   <= op;
            busy_q <= 1'b1;
            div_q  <= op_i[2];
            neg_q  <= na ^ nb;
            negr_q <= na;
            zero_q <= (b_i == '0);
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= op_i[2] ? ma : mb;
            m_q    <= op_i[2] ? mb : ma;
        end else if (busy_q) begin
            busy_q <= ~done_o;
            cnt_q  <= cnt_q + 1'b1;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end
endmodule

// File: rtl/otter_alu_mc.sv
// otter_alu_mc: multi-cycle OTTER execute unit, RV32I ALU with registered result and valid/ready handshakes.
// Define OTTER_ALU_MULDIV_EN to add the iterative RV32M datapath; otherwise M ops complete at once as illegal.
module otter_alu_mc
    import otter_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      alu_fun_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] alu_out_o,
    output logic            illegal_o
);
    localparam int SHW = $clog2(XLEN);
`ifdef OTTER_ALU_MULDIV_EN
    localparam logic MD_EN = 1'b1;
`else
    localparam logic MD_EN = 1'b0;
`endif
    alu_state_t      state_q, state_d;
    logic [XLEN-1:0] res_q, res_d, base_res, md_res;
    logic            ill_q, ill_d, base_ill, md_done, accept, m_op;
    assign m_op        = alu_fun_i[4];
    assign in_ready_o  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready_i);
    assign accept      = in_valid_i & in_ready_o;
    assign out_valid_o = (state_q == ST_DONE);
    assign alu_out_o   = res_q;
    assign illegal_o   = ill_q;
`ifdef OTTER_ALU_MULDIV_EN
    otter_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (accept & m_op & ~flush_i),
        .op_i     (alu_fun_i[2:0]),
        .a_i      (a_i),
        .b_i      (b_i),
        .done_o   (md_done),
        .result_o (md_res)
    );
`else
    assign md_done = 1'b0;
    assign md_res  = '0;
`endif
    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (alu_op_t'(alu_fun_i[3:0]))
            ALU_ADD:  base_res = a_i + b_i;
            ALU_SUB:  base_res = a_i - b_i;
            ALU_OR:   base_res = a_i | b_i;
            ALU_AND:  base_res = a_i & b_i;
            ALU_XOR:  base_res = a_i ^ b_i;
            ALU_SRL:  base_res = a_i >> b_i[SHW-1:0];
            ALU_SLL:  base_res = a_i << b_i[SHW-1:0];
            ALU_SRA:  base_res = $signed(a_i) >>> b_i[SHW-1:0];
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_LUI:  base_res = a_i;
            default:  base_ill = 1'b1;
        endcase
    end
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ill_d   = ill_q;
        if (state_q == ST_DONE && out_ready_i) state_d = ST_IDLE;
        if (state_q == ST_BUSY && md_done) begin
            state_d = ST_DONE;
            res_d   = md_res;
            ill_d   = 1'b0;
        end
        if (accept) begin
            state_d = (m_op && MD_EN) ? ST_BUSY : ST_DONE;
            res_d   = m_op ? '0 : base_res;
            ill_d   = m_op ? ~MD_EN : base_ill;
        end
        if (flush_i) state_d = ST_IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ill_q   <= ill_d;
        end
    end
endmodule
